// File: rtl/led_pio_pkg.sv
// rtl/led_pio_pkg.sv - register map constants shared by the LED PIO slave and its bench
package led_pio_pkg;

  localparam logic [2:0] LED_PIO_DATA       = 3'd0;
  localparam logic [2:0] LED_PIO_SET        = 3'd1;
  localparam logic [2:0] LED_PIO_CLEAR      = 3'd2;
  localparam logic [2:0] LED_PIO_BLINK_MASK = 3'd3;
  localparam logic [2:0] LED_PIO_PERIOD     = 3'd4;
  localparam logic [2:0] LED_PIO_STATUS     = 3'd5;

  localparam int LED_PIO_STATUS_PHASE_BIT = 0;

endpackage

// File: rtl/led_blink_timer.sv
// rtl/led_blink_timer.sv - half-period down-counter producing the shared blink phase
module led_blink_timer #(
  parameter int PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [PERIOD_W-1:0] period,
  input  logic                load,
  output logic                phase,
  output logic                phase_next
);

  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic                phase_q, phase_d;

  // A load restarts the sequence lit; period 0 parks the timer lit.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (load || period == '0) begin
      cnt_d   = period;
      phase_d = 1'b1;
    end else if (cnt_q == '0) begin
      cnt_d   = period;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q - PERIOD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase      = phase_q;
  assign phase_next = phase_d;

endmodule

// File: rtl/led_pio_ctrl.sv
// rtl/led_pio_ctrl.sv - zero-wait LED output port with set/clear and optional blink (LED_PIO_BLINK_EN)
module led_pio_ctrl
  import led_pio_pkg::*;
#(
  parameter int               WIDTH       = 18,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               PERIOD_W    = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic             wr_en;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] out_d;
  logic             unused_wd;

  assign wr_en     = chipselect & ~write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;

  always_comb begin
    data_d = data_q;
    if (wr_en) begin
      case (address)
        LED_PIO_DATA:  data_d = wd;
        LED_PIO_SET:   data_d = data_q | wd;
        LED_PIO_CLEAR: data_d = data_q & ~wd;
        default:       data_d = data_q;
      endcase
    end
  end

`ifdef LED_PIO_BLINK_EN
  logic [WIDTH-1:0]    mask_q, mask_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                period_load;
  logic                phase, phase_next;

  assign period_load = wr_en && (address == LED_PIO_PERIOD);
  assign mask_d      = (wr_en && address == LED_PIO_BLINK_MASK) ? wd : mask_q;
  assign period_d    = period_load ? writedata[PERIOD_W-1:0] : period_q;

  led_blink_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .period     (period_d),
    .load       (period_load),
    .phase      (phase),
    .phase_next (phase_next)
  );

  // Blinking bits follow the phase the timer settles to on this same edge.
  assign out_d = data_d & (~mask_d | {WIDTH{phase_next}});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q   <= '0;
      period_q <= '0;
    end else begin
      mask_q   <= mask_d;
      period_q <= period_d;
    end
  end
`else
  assign out_d = data_d;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q   <= RESET_VALUE;
      out_port <= RESET_VALUE;
    end else begin
      data_q   <= data_d;
      out_port <= out_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      LED_PIO_DATA:       readdata[WIDTH-1:0] = data_q;
`ifdef LED_PIO_BLINK_EN
      LED_PIO_BLINK_MASK: readdata[WIDTH-1:0] = mask_q;
      LED_PIO_PERIOD:     readdata[PERIOD_W-1:0] = period_q;
      LED_PIO_STATUS:     readdata[LED_PIO_STATUS_PHASE_BIT] = phase;
`endif
      default:            readdata = '0;
    endcase
  end

endmodule

// File: doc/led_pio_ctrl.md
# led_pio_ctrl

Parametrised Avalon-MM output port for board LEDs, successor to the fixed 18-bit LED port. It provides atomic set/clear registers for individual bits and a per-bit hardware blink function driven by a programmable prescaler, so software no longer toggles LEDs in a loop. It sits on the system interconnect as a zero-wait-state slave with its outputs wired to the LED pins.

## Interface
- WIDTH, 18: number of output bits, 1..32.
- RESET_VALUE, 0: value loaded into DATA on reset, WIDTH bits.
- PERIOD_W, 24: width of the blink half-period counter and register, 1..32.

- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  3  word offset.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data; only bits [WIDTH-1:0] or [PERIOD_W-1:0] are used.
- readdata  out  32  combinational read data; unused upper bits are 0.
- out_port  out  WIDTH  LED drive, registered.

## Operation
- A write occurs when chipselect=1 and write_n=0; at most one write per cycle.
- Register map (word offsets):
  - 0 DATA (RW): write replaces DATA.
  - 1 SET (WO): DATA |= wd.
  - 2 CLEAR (WO): DATA &= ~wd.
  - 3 BLINK_MASK (RW): bits set to 1 blink.
  - 4 PERIOD (RW): half-period in clk cycles minus 1.
  - 5 STATUS (RO): bit0 = current blink phase.
  - 6..7: reserved.
- Reads:
  - SET and CLEAR read as 0.
  - Reserved offsets read 0; writes to them and to STATUS are ignored.
- Blink timer:
  - Down-counter cnt, PERIOD_W bits.
  - When PERIOD == 0: timer halted, cnt = 0, phase = 1.
  - Otherwise, each cycle: if cnt == 0, then cnt <= PERIOD and phase <= ~phase; else cnt <= cnt-1.
  - Writing PERIOD loads cnt <= new value and forces phase <= 1 in the same edge, restarting the sequence.
- Output: out_port <= DATA_next & (~BLINK_MASK_next | {WIDTH{phase_next}}). The output is registered and reflects a write on the edge after that write.
- Reset values:
  - DATA = RESET_VALUE.
  - BLINK_MASK = 0.
  - PERIOD = 0.
  - cnt = 0.
  - phase = 1.
  - out_port = RESET_VALUE.
- Asserting reset mid-blink returns to the reset values immediately (asynchronous). Blinking resumes only after PERIOD is rewritten.

## Timing
- Read latency 0: readdata is valid in the same cycle address is presented; no waitrequest.
- Register write to out_port change: 1 clk.
- Blink half-period: PERIOD+1 cycles, so a full cycle is 2*(PERIOD+1) cycles.
- A write to BLINK_MASK or DATA does not disturb cnt or phase.

## Configuration
- LED_PIO_BLINK_EN defined: blink timer, BLINK_MASK, PERIOD and STATUS are implemented as described.
- LED_PIO_BLINK_EN not defined:
  - No timer logic is built.
  - Offsets 3..5 behave as reserved: they read 0 and ignore writes.
  - out_port equals DATA registered.
  - The DATA/SET/CLEAR behaviour is unchanged.

## Structure
- Shared package led_pio_pkg holds:
  - register offset constants (LED_PIO_DATA=0 … LED_PIO_STATUS=5);
  - a STATUS bit-position constant.
- Sub-module led_blink_timer, parameter PERIOD_W:
  - inputs: clk, reset_n, period, load;
  - output: phase.
  - It is instantiated only under LED_PIO_BLINK_EN.

## Test plan
- Reset with RESET_VALUE=18'h00AA0 → out_port=18'h00AA0, readdata at offset 0 = 32'h00AA0, offset 5 reads 1.
- Write DATA=0x3F000, then SET=0x0000F, then CLEAR=0x01000 → DATA reads 0x3E00F; out_port updates 1 cycle after each write.
- Write writedata=32'hFFFFFFFF to DATA with WIDTH=18 → reads 32'h0003FFFF; reserved offset 6 reads 0 after a write of 0x1234.
- With DATA=0x3, BLINK_MASK=0x1 and PERIOD=4 → bit0 toggles every 5 cycles (10-cycle period) and bit1 stays 1; STATUS bit0 tracks phase.
- Rewrite PERIOD=2 mid-half-period → phase forced to 1 on that edge and the next toggle occurs 3 cycles later; then write PERIOD=0 → blink stops with the bit lit.
- Pulse reset_n low for 3 ns mid-blink → all registers at reset values immediately and out_port=RESET_VALUE with no further toggling. Build without LED_PIO_BLINK_EN → offset 3 reads 0 after writing 0x1.
